// File: rtl/ika9958_pkg.sv
// Shared lock-state type and clock-mode constants for the IKA9958 clock generator.
package ika9958_pkg;

  localparam int CM_MASTER = 0;
  localparam int CM_SLAVE  = 1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_e;

endpackage

// File: rtl/ika9958_sync2.sv
// Two-flop synchroniser for an asynchronous input with a falling-edge detector
// on the synchronised level.
module ika9958_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
    prev_d = sync_q[1];
  end

  // Flops idle high so a low input after reset still registers as a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign fall_o = prev_q & ~sync_q[1];

endmodule

// File: rtl/ika9958_clkgen.sv
// DLCLK/DHCLK phase generator: free-running from the master tick, or locked to an
// external DLCLK whose falling edges re-align the phase counter.
module ika9958_clkgen
  import ika9958_pkg::*;
#(
  parameter int CM       = CM_MASTER,
  parameter int DIV      = 4,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                    i_XTAL1,
  input  logic                    i_RST_n,
  input  logic                    i_XTAL_NCEN,
  input  logic                    i_DLCLK_n,
  output logic                    o_DHCLK_n,
  output logic                    o_DLCLK_n,
  output logic                    o_DLCLK_PCEN,
  output logic                    o_DLCLK_NCEN,
  output logic [$clog2(DIV)-1:0]  o_PHASE,
  output logic                    o_LOCKED
);

  localparam int            PW         = $clog2(DIV);
  localparam logic [PW-1:0] PH_LAST    = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_HALF    = PW'(DIV / 2);
  localparam logic [PW-1:0] PH_HALF_M1 = PW'(DIV / 2 - 1);

  logic          tick;
  logic          force_zero;
  logic [PW-1:0] phase_q, phase_d;
  logic          dhclk_q, dhclk_d;
  logic          dlclk_q, dlclk_d;
  logic          pcen_q, pcen_d;
  logic          ncen_q, ncen_d;

  assign tick = i_XTAL_NCEN;

  generate
    if (CM == CM_SLAVE) begin : g_slave
      localparam int                CW        = $clog2(TIMEOUT + 1);
      localparam int                MW        = $clog2(LOCK_CNT + 1);
      localparam logic [CW-1:0]     CNT_MAX   = CW'(TIMEOUT);
      localparam logic [CW:0]       MEAS_DIV  = (CW + 1)'(DIV);
      localparam logic [MW-1:0]     MATCH_TGT = MW'(LOCK_CNT);

      logic          fall;
      lock_state_e   state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [MW-1:0] match_q, match_d;
      logic [CW:0]   measured;
      logic          locked_q;

      ika9958_sync2 u_sync (
        .clk_i  (i_XTAL1),
        .rst_ni (i_RST_n),
        .d_i    (i_DLCLK_n),
        .fall_o (fall)
      );

      // A tick landing on the edge cycle still belongs to the period being closed.
      always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        match_d    = match_q;
        force_zero = 1'b0;
        measured   = {1'b0, cnt_q} + {{CW{1'b0}}, tick};
        if (fall) begin
          cnt_d = '0;
          case (state_q)
            UNLOCKED: begin
              force_zero = 1'b1;
              match_d    = '0;
              state_d    = ACQUIRE;
            end
            ACQUIRE: begin
              force_zero = 1'b1;
              if (measured == MEAS_DIV) begin
                match_d = match_q + MW'(1);
                if (match_d == MATCH_TGT) state_d = LOCKED;
              end else begin
                match_d = '0;
              end
            end
            LOCKED: begin
              if (measured != MEAS_DIV) begin
                force_zero = 1'b1;
                match_d    = '0;
                state_d    = ACQUIRE;
              end
            end
            default: state_d = UNLOCKED;
          endcase
        end else begin
          if (tick && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CW'(1);
          if (cnt_d == CNT_MAX) state_d = UNLOCKED;
        end
      end

      always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
        if (!i_RST_n) begin
          state_q  <= UNLOCKED;
          cnt_q    <= '0;
          match_q  <= '0;
          locked_q <= 1'b0;
        end else begin
          state_q  <= state_d;
          cnt_q    <= cnt_d;
          match_q  <= match_d;
          locked_q <= (state_d == LOCKED);
        end
      end

      assign o_LOCKED = locked_q;
    end else begin : g_master
      logic unused_cfg;
      assign unused_cfg = ^{i_DLCLK_n, 1'(LOCK_CNT), 1'(TIMEOUT)};
      assign force_zero = 1'b0;
      assign o_LOCKED   = 1'b0;
    end
  endgenerate

  // A forced re-align wins over a tick; PCEN only fires when phase actually returns to 0.
  always_comb begin
    phase_d = phase_q;
    if (force_zero) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    end
    dhclk_d = tick ? ~dhclk_q : dhclk_q;
    dlclk_d = (phase_d >= PH_HALF);
    pcen_d  = tick && (phase_d == '0) && (phase_q != '0);
    ncen_d  = tick && (phase_q == PH_HALF_M1) && (phase_d == PH_HALF);
  end

  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      phase_q <= '0;
      dhclk_q <= 1'b1;
      dlclk_q <= 1'b0;
      pcen_q  <= 1'b0;
      ncen_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      dhclk_q <= dhclk_d;
      dlclk_q <= dlclk_d;
      pcen_q  <= pcen_d;
      ncen_q  <= ncen_d;
    end
  end

  assign o_PHASE      = phase_q;
  assign o_DHCLK_n    = dhclk_q;
  assign o_DLCLK_n    = dlclk_q;
  assign o_DLCLK_PCEN = pcen_q;
  assign o_DLCLK_NCEN = ncen_q;

endmodule

// File: tb/tb_ika9958_clkgen.sv
// Bench for ika9958_clkgen: a master-mode and a slave-mode instance share stimulus;
// a cycle model feeds a scoreboard, and scenario checks pin down lock timing.
module tb_ika9958_clkgen;
  import ika9958_pkg::*;

  localparam int DIV  = 4;
  localparam int LOCK = 4;
  localparam int TMO  = 64;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  logic tick = 1'b0;
  logic dlIn = 1'b1;

  logic       dhclk0, dlclk0, pcen0, ncen0, locked0;
  logic       dhclk1, dlclk1, pcen1, ncen1, locked1;
  logic [1:0] phase0, phase1;
  logic [6:0] outs0, outs1;
  logic [4:0] fsm1;

  always #5 clk = ~clk;

  ika9958_clkgen #(.CM(CM_MASTER), .DIV(DIV), .LOCK_CNT(LOCK), .TIMEOUT(TMO)) dut0 (
    .i_XTAL1(clk), .i_RST_n(rstN), .i_XTAL_NCEN(tick), .i_DLCLK_n(dlIn),
    .o_DHCLK_n(dhclk0), .o_DLCLK_n(dlclk0), .o_DLCLK_PCEN(pcen0), .o_DLCLK_NCEN(ncen0),
    .o_PHASE(phase0), .o_LOCKED(locked0)
  );

  ika9958_clkgen #(.CM(CM_SLAVE), .DIV(DIV), .LOCK_CNT(LOCK), .TIMEOUT(TMO)) dut1 (
    .i_XTAL1(clk), .i_RST_n(rstN), .i_XTAL_NCEN(tick), .i_DLCLK_n(dlIn),
    .o_DHCLK_n(dhclk1), .o_DLCLK_n(dlclk1), .o_DLCLK_PCEN(pcen1), .o_DLCLK_NCEN(ncen1),
    .o_PHASE(phase1), .o_LOCKED(locked1)
  );

  assign outs0 = {locked0, ncen0, pcen0, dlclk0, dhclk0, phase0};
  assign outs1 = {locked1, ncen1, pcen1, dlclk1, dhclk1, phase1};
  assign fsm1  = {dut1.g_slave.state_q, dut1.g_slave.match_q};

  typedef struct {
    int phase;
    bit dh, dl, pcen, ncen, locked;
    int st, cnt, match;
    bit s1, s2, s3;
  } model_t;

  typedef struct packed {
    logic [6:0] o0;
    logic [6:0] o1;
    logic [4:0] f1;
  } exp_t;

  model_t m0, m1;
  exp_t   sbQ[$];
  int     errors = 0;
  int     checks = 0;
  int     edgeCount, lockEdge, lastEdgeLocked, lastEdgeState, lastEdgeMatch, prePhase;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic model_t modelReset();
    model_t r;
    r.phase = 0; r.dh = 1'b1; r.dl = 1'b0; r.pcen = 1'b0; r.ncen = 1'b0; r.locked = 1'b0;
    r.st = 0; r.cnt = 0; r.match = 0;
    r.s1 = 1'b1; r.s2 = 1'b1; r.s3 = 1'b1;
    return r;
  endfunction

  // Behavioural reference: st 0/1/2 = unlocked/acquire/locked, edge seen when the
  // second synchroniser stage has fallen relative to the previous sample.
  function automatic model_t modelStep(model_t m, bit slave, bit tk, bit dl);
    model_t n = m;
    bit     fell;
    bit     forceZero = 1'b0;
    int     meas;
    fell = slave && m.s3 && !m.s2;
    if (slave) begin
      n.s1 = dl; n.s2 = m.s1; n.s3 = m.s2;
      meas = m.cnt + int'(tk);
      if (fell) begin
        n.cnt = 0;
        if (m.st == 0) begin
          forceZero = 1'b1; n.match = 0; n.st = 1;
        end else if (m.st == 1) begin
          forceZero = 1'b1;
          n.match = (meas == DIV) ? m.match + 1 : 0;
          if (n.match == LOCK) n.st = 2;
        end else if (meas != DIV) begin
          forceZero = 1'b1; n.match = 0; n.st = 1;
        end
      end else begin
        n.cnt = (meas > TMO) ? TMO : meas;
        if (n.cnt == TMO) n.st = 0;
      end
    end
    n.phase  = forceZero ? 0 : (tk ? (m.phase + 1) % DIV : m.phase);
    n.dh     = tk ? !m.dh : m.dh;
    n.dl     = (n.phase >= DIV / 2);
    n.pcen   = tk && (forceZero ? (m.phase != 0) : (m.phase == DIV - 1));
    n.ncen   = tk && !forceZero && (m.phase == DIV / 2 - 1);
    n.locked = (n.st == 2);
    return n;
  endfunction

  function automatic logic [6:0] packExp(model_t m);
    return {m.locked, m.ncen, m.pcen, m.dl, m.dh, 2'(m.phase)};
  endfunction

  // One clock: drive at the falling edge, push the expectation, return after the rising edge.
  task automatic applyStimulus(input bit rst, input bit tk, input bit dl);
    exp_t e;
    @(negedge clk);
    rstN = rst; tick = tk; dlIn = dl;
    if (!rst) begin
      m0 = modelReset(); m1 = modelReset();
    end else begin
      m0 = modelStep(m0, 1'b0, tk, dl);
      m1 = modelStep(m1, 1'b1, tk, dl);
    end
    e.o0 = packExp(m0);
    e.o1 = packExp(m1);
    e.f1 = {2'(m1.st), 3'(m1.match)};
    sbQ.push_back(e);
    if (!rst) begin
      #1;
      checkOutput("rstImm0", 32'(outs0), 32'(e.o0));
      checkOutput("rstImm1", 32'(outs1), 32'(e.o1));
      checkOutput("rstImmFsm", 32'(fsm1), 32'(e.f1));
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("outs0", 32'(outs0), 32'(e.o0));
        checkOutput("outs1", 32'(outs1), 32'(e.o1));
        checkOutput("fsm1", 32'(fsm1), 32'(e.f1));
      end
    end
  end

  task automatic resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  // One external DLCLK period of nTicks ticks (4 clocks each), low half first.
  task automatic runPeriod(input int nTicks);
    int len = 4 * nTicks;
    edgeCount++;
    for (int i = 0; i < len; i++) begin
      applyStimulus(1'b1, (i % 4) == 0, i >= len / 2);
      if (i == 1) prePhase = int'(phase1);
      if (i == 2) begin
        checkOutput("edgePhase", 32'(phase1), 32'(0));
        lastEdgeLocked = int'(locked1);
        lastEdgeState  = int'(dut1.g_slave.state_q);
        lastEdgeMatch  = int'(dut1.g_slave.match_q);
        if (locked1 && lockEdge == 0) lockEdge = edgeCount;
      end
    end
  endtask

  initial begin
    int dlHigh, pcenCnt, ncenCnt, dhToggles, lockedCnt, firstPcen, lastPcen, firstNcen;
    logic prevDh;

    $display("[TB] master mode free-run");
    resetDut();
    dlHigh = 0; pcenCnt = 0; ncenCnt = 0; dhToggles = 0; lockedCnt = 0;
    firstPcen = -1; lastPcen = -1; firstNcen = -1; prevDh = 1'b1;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, (i % 4) == 0, 1'b1);
      dlHigh    += int'(dlclk0);
      lockedCnt += int'(locked0);
      if (dhclk0 != prevDh) dhToggles++;
      prevDh = dhclk0;
      if (pcen0) begin
        pcenCnt++; lastPcen = i;
        if (firstPcen < 0) firstPcen = i;
      end
      if (ncen0) begin
        ncenCnt++;
        if (firstNcen < 0) firstNcen = i;
      end
    end
    checkOutput("m0DlHigh", 32'(dlHigh), 32'(32));
    checkOutput("m0DhToggles", 32'(dhToggles), 32'(16));
    checkOutput("m0Pcen", 32'(pcenCnt), 32'(4));
    checkOutput("m0Ncen", 32'(ncenCnt), 32'(4));
    checkOutput("m0FirstPcen", 32'(firstPcen), 32'(12));
    checkOutput("m0LastPcen", 32'(lastPcen), 32'(60));
    checkOutput("m0FirstNcen", 32'(firstNcen), 32'(4));
    checkOutput("m0Locked", 32'(lockedCnt), 32'(0));

    $display("[TB] slave lock from reset");
    resetDut();
    edgeCount = 0; lockEdge = 0;
    repeat (6) runPeriod(4);
    checkOutput("lockRegular", 32'(lockEdge), 32'(5));

    $display("[TB] slave irregular then regular periods");
    resetDut();
    edgeCount = 0; lockEdge = 0;
    for (int p = 1; p <= 4; p++) begin
      runPeriod(5);
      if (p >= 2) checkOutput("matchClr", 32'(lastEdgeMatch), 32'(0));
    end
    runPeriod(4);
    checkOutput("matchClr5", 32'(lastEdgeMatch), 32'(0));
    repeat (4) runPeriod(4);
    checkOutput("lockIrregular", 32'(lockEdge), 32'(9));

    $display("[TB] slave timeout while locked");
    for (int k = 0; k < 270; k++) begin
      applyStimulus(1'b1, (k % 4) == 0, k >= 8);
      if (k == 255) checkOutput("toHold", 32'(locked1), 32'(1));
      if (k == 256) begin
        checkOutput("toDrop", 32'(locked1), 32'(0));
        checkOutput("toPhase0", 32'(phase1), 32'(0));
      end
      if (k == 260) checkOutput("toPhase1", 32'(phase1), 32'(1));
      if (k == 264) checkOutput("toPhase2", 32'(phase1), 32'(2));
    end
    checkOutput("toState", 32'(dut1.g_slave.state_q), 32'(UNLOCKED));

    $display("[TB] slave short period while locked");
    edgeCount = 0; lockEdge = 0;
    repeat (5) runPeriod(4);
    checkOutput("relock", 32'(lockEdge), 32'(5));
    runPeriod(3);
    runPeriod(4);
    checkOutput("shortPrePhase", 32'(prePhase), 32'(3));
    checkOutput("shortLocked", 32'(lastEdgeLocked), 32'(0));
    checkOutput("shortState", 32'(lastEdgeState), 32'(ACQUIRE));
    checkOutput("shortMatch", 32'(lastEdgeMatch), 32'(0));

    $display("[TB] reset during acquire");
    resetDut();
    edgeCount = 0; lockEdge = 0;
    repeat (4) runPeriod(4);
    checkOutput("match3", 32'(dut1.g_slave.match_q), 32'(3));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, (i % 4) == 0, 1'b1);
    resetDut();
    edgeCount = 0; lockEdge = 0;
    repeat (6) runPeriod(4);
    checkOutput("lockAfterReset", 32'(lockEdge), 32'(5));

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ika9958_clkgen.md
IKA9958_CLKGEN -- requirements
Module: ika9958_clkgen

Interface
REQ-001 SHALL have parameter CM, default 0, meaning clock mode (0 = internal master, 1 = slave to external i_DLCLK_n).
REQ-002 SHALL have parameter DIV, default 4, meaning enable ticks per DLCLK period (even, 2..16).
REQ-003 SHALL have parameter LOCK_CNT, default 4, meaning consecutive good external periods needed to lock (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 64, meaning enable ticks without an external edge before lock is dropped (> DIV).
REQ-005 SHALL have port i_XTAL1, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port i_RST_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_XTAL_NCEN, input, 1 bit: master tick qualifier, active high; one tick per asserted cycle.
REQ-008 SHALL have port i_DLCLK_n, input, 1 bit: external DLCLK, asynchronous; ignored when CM=0.
REQ-009 SHALL have port o_DHCLK_n, output, 1 bit: half-rate clock level, toggles every tick.
REQ-010 SHALL have port o_DLCLK_n, output, 1 bit: DLCLK level; low for phase < DIV/2, else high.
REQ-011 SHALL have port o_DLCLK_PCEN, output, 1 bit: one-cycle pulse on the tick where phase wraps DIV-1 -> 0.
REQ-012 SHALL have port o_DLCLK_NCEN, output, 1 bit: one-cycle pulse on the tick where phase goes DIV/2-1 -> DIV/2.
REQ-013 SHALL have port o_PHASE, output, $clog2(DIV) bits: current phase counter.
REQ-014 SHALL have port o_LOCKED, output, 1 bit: external lock achieved; constant 0 when CM=0.

Function
REQ-015 SHALL increment phase modulo DIV on each tick; no change on cycles without a tick.
REQ-016 SHALL register all outputs; level outputs and enable pulses SHALL reflect the phase after the updating edge, with zero added latency.
REQ-017 SHALL (CM=1) pass i_DLCLK_n through a 2-flop synchroniser and detect falling edges on the synchronised signal, with 3-cycle detection latency from the input transition.
REQ-018 SHALL (CM=1) count ticks in a period counter; on an edge cycle, the measured period = counter + (tick this cycle ? 1 : 0); the counter then clears to 0.
REQ-019 SHALL use lock FSM states UNLOCKED, ACQUIRE and LOCKED.
REQ-020 SHALL, in UNLOCKED, force phase to 0 on the first edge, clear the match count and enter ACQUIRE.
REQ-021 SHALL, in ACQUIRE: on each edge force phase to 0; measured == DIV increments the match count; any other value clears it.
REQ-022 SHALL enter LOCKED from ACQUIRE when the match count reaches LOCK_CNT; o_LOCKED SHALL be 1 only in LOCKED.
REQ-023 SHALL, in LOCKED, let phase free-run without forcing; an edge with measured != DIV SHALL force phase to 0 and return the FSM to ACQUIRE with match count 0.
REQ-024 SHALL drop to UNLOCKED from any state when the period counter reaches TIMEOUT with no edge; the counter SHALL saturate there, and phase SHALL free-run.
REQ-025 SHALL, when a forced phase = 0 coincides with a tick, give the force priority; o_DLCLK_PCEN SHALL pulse on that cycle only if phase was not already 0.
REQ-026 SHALL, when CM=0, omit the synchroniser, the FSM and the period counter from synthesis.

Reset
REQ-027 SHALL, on i_RST_n low, immediately set phase=0, o_DHCLK_n=1, o_DLCLK_n=0, both enable pulses=0, o_LOCKED=0, FSM=UNLOCKED, counters=0 and synchroniser flops=1.
REQ-028 SHALL resume ticking on the first tick after reset deassertion; reset mid-acquire SHALL discard all lock progress.

Structure
REQ-029 SHALL place the lock-state enum and clock-mode constants in the shared package ika9958_pkg.
REQ-030 SHALL implement the synchroniser plus falling-edge detector as sub-module ika9958_sync2.

Verification
REQ-031 SHALL cover: CM=0, DIV=4, tick every 4th clock -> o_DLCLK_n period 16 clocks at 50% duty, o_DHCLK_n period 8 clocks, one PCEN and one NCEN pulse per 16 clocks, o_LOCKED=0.
REQ-032 SHALL cover: CM=1, external half-period 8 clocks from reset -> o_LOCKED rises on the 4th consecutive 4-tick period, and phase is 0 at every falling edge.
REQ-033 SHALL cover: CM=1, 4 irregular 5-tick periods then regular 4-tick periods -> match count clears on each 5-tick period, and lock comes 4 regular periods later.
REQ-034 SHALL cover: CM=1 while locked, i_DLCLK_n held high for 64 ticks -> o_LOCKED falls on tick 64, and phase keeps free-running.
REQ-035 SHALL cover: CM=1 while locked, one 3-tick period -> phase forced to 0, o_LOCKED=0, FSM=ACQUIRE.
REQ-036 SHALL cover: reset asserted mid-ACQUIRE with match count 3 -> all outputs at reset values within the same cycle; relock needs 4 fresh good periods.
